cla_nibble_seq_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit carry-lookahead adder, one nibble per clock, LSB nibble first.
- Latches operands on a start handshake, drives the adder's A/B/Cin each RUN cycle and captures its sum/carry-out.
- Presents the assembled result with carry-out and signed-overflow flags on a one-cycle done strobe.
- Sits between the ALU front-end and the shared 4-bit CLA datapath.

---
 rtl/cla_nibble_seq_ctrl_if.sv | 32 +++
 rtl/cla_nibble_seq_ctrl.sv | 106 ++++++++++
 tb/tb_cla_nibble_seq_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_seq_ctrl_if.sv
// Bundle between the ALU front-end, the nibble sequencer and the shared 4-bit CLA.
// master = front-end/datapath side, slave = sequencer.
interface cla_nibble_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_cin;
  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             done;
  logic             busy;

  modport master (
    output start, op_a, op_b, cin, sub, cla_sum, cla_cout,
    input  ready, cla_a, cla_b, cla_cin, result, cout, ovf, done, busy
  );

  modport slave (
    input  start, op_a, op_b, cin, sub, cla_sum, cla_cout,
    output ready, cla_a, cla_b, cla_cin, result, cout, ovf, done, busy
  );
endinterface

// File: rtl/cla_nibble_seq_ctrl.sv
// WIDTH-bit add/subtract built by feeding one external 4-bit CLA a nibble per
// clock, LSB first, and assembling the sum with carry-out and overflow flags.
module cla_nibble_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  cla_nibble_seq_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       nibA, nibB;
  logic             nibCin;

  // Next-state and adder drive; b_q already holds ~op_b for subtraction.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    nibA     = 4'h0;
    nibB     = 4'h0;
    nibCin   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub ? 1'b1 : bus.cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        nibA   = a_q[{idx_q, 2'b00} +: 4];
        nibB   = b_q[{idx_q, 2'b00} +: 4];
        nibCin = carry_q;
        result_d[{idx_q, 2'b00} +: 4] = bus.cla_sum;
        carry_d = bus.cla_cout;
        if (idx_q == LAST) begin
          cout_d  = bus.cla_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.cla_sum[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == RUN) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.cla_a   = nibA;
  assign bus.cla_b   = nibB;
  assign bus.cla_cin = nibCin;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Directed bench for cla_nibble_seq_ctrl at WIDTH=16 with a 4-bit lookahead
// adder modelled locally as the shared datapath.
module tb_cla_nibble_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  cla_nibble_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit carry-lookahead adder acting as the external datapath.
  logic [3:0] claG, claP;
  logic [4:0] claC;
  always_comb begin
    claG    = bus.cla_a & bus.cla_b;
    claP    = bus.cla_a ^ bus.cla_b;
    claC    = '0;
    claC[0] = bus.cla_cin;
    claC[1] = claG[0] | (claP[0] & claC[0]);
    claC[2] = claG[1] | (claP[1] & claG[0]) | (claP[1] & claP[0] & claC[0]);
    claC[3] = claG[2] | (claP[2] & claG[1]) | (claP[2] & claP[1] & claG[0])
            | (claP[2] & claP[1] & claP[0] & claC[0]);
    claC[4] = claG[3] | (claP[3] & claG[2]) | (claP[3] & claP[2] & claG[1])
            | (claP[3] & claP[2] & claP[1] & claG[0])
            | (claP[3] & claP[2] & claP[1] & claP[0] & claC[0]);
    bus.cla_sum  = claP ^ claC[3:0];
    bus.cla_cout = claC[4];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One full operation: accept, per-nibble adder drive checks, done strobe, return to idle.
  task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s, input logic [15:0] expRes,
                               input logic expCout, input logic expOvf);
    logic [15:0] bEff;
    logic        carry;
    logic [4:0]  nibSum;
    bEff  = s ? ~b : b;
    carry = s ? 1'b1 : c;
    @(negedge clk);
    checkOutput({name, "/readyIdle"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.sub   = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = a ^ b;
    bus.cin   = ~c;
    bus.sub   = ~s;
    for (int i = 0; i < NIB; i++) begin
      if (i == 0) checkOutput({name, "/resultCleared"}, 32'(bus.result[3:0]), 32'd0);
      checkOutput($sformatf("%s/claA%0d", name, i), 32'(bus.cla_a), 32'(a[4*i +: 4]));
      checkOutput($sformatf("%s/claB%0d", name, i), 32'(bus.cla_b), 32'(bEff[4*i +: 4]));
      checkOutput($sformatf("%s/claCin%0d", name, i), 32'(bus.cla_cin), 32'(carry));
      checkOutput($sformatf("%s/busy%0d", name, i), 32'({bus.busy, bus.ready, bus.done}), 32'b100);
      nibSum = {1'b0, a[4*i +: 4]} + {1'b0, bEff[4*i +: 4]} + {4'b0, carry};
      carry  = nibSum[4];
      @(negedge clk);
    end
    checkOutput({name, "/done"}, 32'({bus.busy, bus.ready, bus.done}), 32'b101);
    checkOutput({name, "/result"}, 32'(bus.result), 32'(expRes));
    checkOutput({name, "/cout"}, 32'(bus.cout), 32'(expCout));
    checkOutput({name, "/ovf"}, 32'(bus.ovf), 32'(expOvf));
    checkOutput({name, "/claIdle"}, 32'({bus.cla_a, bus.cla_b, bus.cla_cin}), 32'd0);
    @(negedge clk);
    checkOutput({name, "/backIdle"}, 32'({bus.busy, bus.ready, bus.done}), 32'b010);
    checkOutput({name, "/resultHeld"}, 32'(bus.result), 32'(expRes));
  endtask

  function automatic logic [15:0] heldA(input int c);
    return 16'h1000 + 16'(c) * 16'h0111;
  endfunction

  function automatic logic [15:0] heldB(input int c);
    return 16'(c * 3);
  endfunction

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst/flags", 32'({bus.busy, bus.ready, bus.done}), 32'b010);
    checkOutput("rst/result", 32'(bus.result), 32'd0);
    checkOutput("rst/coutOvf", 32'({bus.cout, bus.ovf}), 32'd0);
    checkOutput("rst/cla", 32'({bus.cla_a, bus.cla_b, bus.cla_cin}), 32'd0);
    rst = 1'b0;

    applyStimulus("add5p3",   16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0);
    applyStimulus("rippleAll", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("sub1234",  16'h1234, 16'h0235, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    applyStimulus("ovfPos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus("ovfNeg",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus("addCin",   16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    applyStimulus("subEqual", 16'h4321, 16'h4321, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start held high: accepts only every NIB+2 cycles, using that cycle's operands.
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    for (int c = 0; c < 3 * (NIB + 2); c++) begin
      @(negedge clk);
      checkOutput($sformatf("held/ready%0d", c), 32'(bus.ready), 32'((c % (NIB + 2)) == 0));
      checkOutput($sformatf("held/done%0d", c), 32'(bus.done), 32'((c % (NIB + 2)) == NIB + 1));
      if ((c % (NIB + 2)) == NIB + 1)
        checkOutput($sformatf("held/result%0d", c), 32'(bus.result),
                    32'(16'(heldA(c - NIB - 1) + heldB(c - NIB - 1))));
      bus.start = 1'b1;
      bus.op_a  = heldA(c);
      bus.op_b  = heldB(c);
    end
    @(negedge clk);
    bus.start = 1'b0;

    // Reset in RUN cycle 2 abandons the operation silently.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h2222;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstRun/flags", 32'({bus.busy, bus.ready, bus.done}), 32'b010);
    checkOutput("rstRun/result", 32'(bus.result), 32'd0);
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstRun/noDone%0d", i), 32'(bus.done), 32'd0);
    end
    applyStimulus("afterRst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
